// File: rtl/asmd_decryption.sv
// Iterative AES-128 inverse cipher: ASMD control unit plus datapath, one inverse round per clock.
// The round-10 key is derived forward first, then the schedule is walked backwards.
module asmd_decryption (
    input  logic         clock,
    input  logic         reset,
    input  logic         decrypt,
    input  logic [127:0] cipher_text_in,
    input  logic [127:0] key_in,
    output logic         done,
    output logic [127:0] Dout
);

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, LAST, DONE} state_t;

    state_t       st_q, st_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] dout_q, dout_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    // Byte n lives at bits [127-8n -: 8]; row r of column c is byte r+4c.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(r+4*c)) +: 8] = inv_sbox(s[8*(15-(r+4*((c-r+4)%4))) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [7:0]   rc_sel;
    logic [127:0] key_fwd, key_bwd, last_out, round_out;

    // ADDKEY steps back from round key 10 while the counter still reads past the end.
    assign rc_sel    = rcon((st_q == ADDKEY) ? 4'd10 : cnt_q);
    assign key_fwd   = next_key(key_q, rc_sel);
    assign key_bwd   = prev_key(key_q, rc_sel);
    assign last_out  = inv_shift_sub(blk_q) ^ key_q;
    assign round_out = inv_mix_columns(last_out);

    always_comb begin
        st_d   = st_q;
        blk_d  = blk_q;
        key_d  = key_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        case (st_q)
            IDLE, DONE: begin
                if (decrypt) begin
                    blk_d = cipher_text_in;
                    key_d = key_in;
                    cnt_d = 4'd1;
                    st_d  = KEYEXP;
                end
            end
            KEYEXP: begin
                key_d = key_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) st_d = ADDKEY;
            end
            ADDKEY: begin
                blk_d = blk_q ^ key_q;
                key_d = key_bwd;
                cnt_d = 4'd9;
                st_d  = ROUND;
            end
            ROUND: begin
                blk_d = round_out;
                key_d = key_bwd;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) st_d = LAST;
            end
            LAST: begin
                dout_d = last_out;
                st_d   = DONE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            blk_q  <= '0;
            key_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            st_q   <= st_d;
            blk_q  <= blk_d;
            key_q  <= key_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign done = (st_q == DONE);
    assign Dout = dout_q;

endmodule

// File: doc/asmd_decryption.md
Name: asmd_decryption

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher). It is the receive-side counterpart of the encryption core and recovers plaintext from that core's Dout.
- Structured as a control unit (ASMD state machine) plus a datapath. Processes one inverse round per clock.
- Derives the round-10 key on the fly, then walks the key schedule backwards. No 11-entry key RAM.

Parameters:
- None. AES-128 only; Nr = 10 and Nk = 4 are fixed.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
- decrypt  input  1  start request; sampled in IDLE/DONE
- cipher_text_in  input  128  ciphertext; bits [127:120] = byte 0, column-major
- key_in  input  128  cipher key; same byte order
- done  output  1  high while in DONE
- Dout  output  128  recovered plaintext; registered

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, done=0, Dout=0, state register=0, key register=0, round counter=0.
- States: IDLE, KEYEXP, ADDKEY, ROUND, LAST, DONE.
- IDLE/DONE with decrypt=1:
  - Load state<=cipher_text_in and key<=key_in; count<=1; go to KEYEXP.
  - Inputs are captured on this edge only. Later input changes are ignored until the next start.
- KEYEXP (10 edges): forward key expansion.
  - key<=next_key(key, Rcon[count]); count++.
  - On the edge with count=10, go to ADDKEY. The key register then holds round key 10.
- ADDKEY (1 edge): state<=state^key; key<=prev_key(key, Rcon[10]); count<=9; go to ROUND.
- ROUND (9 edges, count 9..1): state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^key).
  - key<=prev_key(key, Rcon[count]); count--.
  - On the edge with count=1, go to LAST. The key register then holds round key 0.
- LAST (1 edge): Dout<=InvSubBytes(InvShiftRows(state))^key; go to DONE.
- DONE: done=1, Dout held stable. decrypt=0 keeps DONE; decrypt=1 starts a new operation exactly as from IDLE, and done drops on that edge.
- Latency: with the start edge as edge 1, done rises after edge 22. Sequence is 1 start + 10 KEYEXP + 1 ADDKEY + 9 ROUND + 1 LAST. Back-to-back period is 22 cycles.
- decrypt is ignored in KEYEXP, ADDKEY, ROUND and LAST. No abort except reset.
- next_key with words w0..w3: w0'=w0^SubWord(RotWord(w3))^Rcon; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- prev_key:
  - w3p=w3^w2; w2p=w2^w1; w1p=w1^w0.
  - w0p=w0^SubWord(RotWord(w3p))^Rcon.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- S-box and inverse S-box:
  - Both are combinational. They may share a GF(2^8) inversion with the forward/inverse affine transform, or use lookup tables.
  - Results must be bit-exact to FIPS-197.
- InvMixColumns: per column, coefficients {0e,0b,0d,09}; xtime reduction polynomial 0x11b.
- InvShiftRows: row r rotated right by r bytes.
- Reset asserted mid-operation: immediate return to IDLE, done=0, Dout=0. The next decrypt starts cleanly.
- Dout updates only in LAST. It is never partially updated during rounds.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, decrypt pulsed 1 cycle -> done rises after edge 22; Dout=00112233445566778899aabbccddeeff.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> Dout=3243f6a8885a308d313198a2e0370734.
- Back-to-back: start C.1, then in DONE hold decrypt=1 with the B vectors -> done drops on that edge, then rises 22 cycles later with the B plaintext.
- Input stability: change cipher_text_in/key_in and toggle decrypt during rounds -> result unchanged; no restart.
- Reset at cycle 12 of an operation -> done=0 and Dout=0 immediately (asynchronous). A subsequent C.1 run still decrypts correctly.
- Loopback: 200 random key/plaintext pairs through the encryption core into this block -> Dout equals the original plaintext every time.
